// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state, access-size decode, load/store codes and byte-lane masks for the LSU.
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
  localparam logic [2:0] LD_BYTE  = 3'b000;
  localparam logic [2:0] LD_HALF  = 3'b001;
  localparam logic [2:0] LD_WORD  = 3'b010;
  localparam logic [2:0] LD_BYTEU = 3'b100;
  localparam logic [2:0] LD_HALFU = 3'b101;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  // Bit 2 of the code is signedness only; the low two bits carry the size.
  function automatic size_t ld_size(input logic [2:0] sel);
    return sel[1:0] == 2'b00 ? SZ_BYTE : sel[1:0] == 2'b01 ? SZ_HALF : SZ_WORD;
  endfunction
endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// lsu_mem_ctrl_align: byte-enable generation, store-data replication and load right-alignment.
module lsu_mem_ctrl_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  size_t       i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  always_comb begin
    o_be    = i_size == SZ_BYTE ? BE_BYTE << i_off : i_size == SZ_HALF ? BE_HALF << i_off : BE_WORD;
    o_wdata = i_size == SZ_BYTE ? {4{i_wdata[7:0]}} : i_size == SZ_HALF ? {2{i_wdata[15:0]}} : i_wdata;
    o_rdata = i_rdata >> {i_off, 3'b000};
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: multi-cycle load/store controller between execute stage and data-memory port.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  input  logic [2:0]        req_ld_sel,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              done,
  output logic              misalign,
  output logic [DWIDTH-1:0] ld_data,
  output logic [2:0]        ld_sel_out
);
  state_t            r_state, w_next;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata, r_ld_data;
  logic [2:0]        r_sel, r_ld_sel;
  logic              r_we, r_mis;
  logic              w_accept, w_mis;
  size_t             w_req_size;
  logic [3:0]        w_be;
  logic [DWIDTH-1:0] w_wdata, w_rdata;

  assign w_accept   = req_valid && r_state == IDLE;
  assign w_req_size = ld_size(req_ld_sel);
  assign w_mis      = (w_req_size == SZ_HALF && req_addr[0]) || (w_req_size == SZ_WORD && req_addr[1:0] != 2'b00);

  lsu_mem_ctrl_align u_align (
    .i_off   (r_addr[1:0]),
    .i_size  (ld_size(r_sel)),
    .i_wdata (r_wdata),
    .i_rdata (mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_accept ? (w_mis ? DONE : REQ) : IDLE;
      REQ:  w_next = mem_req_ready ? (r_we ? DONE : WAIT) : REQ;
      WAIT: w_next = mem_rvalid ? DONE : WAIT;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_mis     <= 1'b0;
      r_ld_data <= '0;
      r_ld_sel  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_sel   <= req_ld_sel;
        r_we    <= req_we;
        r_mis   <= w_mis;
      end
      if (r_state == WAIT && mem_rvalid) begin
        r_ld_data <= w_rdata;
        r_ld_sel  <= r_sel;
      end
    end
  end

  assign req_ready     = r_state == IDLE;
  assign mem_req_valid = r_state == REQ;
  assign mem_addr      = {r_addr[AWIDTH-1:2], 2'b00};
  assign mem_we        = r_we ? w_be : 4'b0000;
  assign mem_wdata     = w_wdata;
  assign done          = r_state == DONE;
  assign misalign      = r_state == DONE && r_mis;
  assign ld_data       = r_ld_data;
  assign ld_sel_out    = r_ld_sel;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed scenario tests for the load/store memory controller.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_ld_sel = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        done, misalign;
  logic [31:0] ld_data;
  logic [2:0]  ld_sel_out;
  int vec = 0, errs = 0;

  lsu_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ld_sel(req_ld_sel),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .done(done), .misalign(misalign), .ld_data(ld_data), .ld_sel_out(ld_sel_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    vec++; if ({mem_req_valid, done, misalign, mem_we} !== 7'b0) begin errs++; $display("FAIL rst_outs got %b exp 0", {mem_req_valid, done, misalign, mem_we}); end
    vec++; if (ld_data !== 32'h0) begin errs++; $display("FAIL rst_ld_data got %h exp 0", ld_data); end
    step();
    rst_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_ld_sel = LD_WORD; mem_req_ready = 1'b0;
    step();
    req_valid = 1'b0;
    vec++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL rst_pre_req got %b exp 1", mem_req_valid); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL rst_async_drop got %b exp 0", mem_req_valid); end
    #2 rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++; if ({done, req_ready} !== 2'b01) begin errs++; $display("FAIL rst_stale_rvalid[%0d] got done,ready=%b exp 01", i, {done, req_ready}); end
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_store_byte();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1003; req_wdata = 32'h000000A5; req_ld_sel = LD_BYTE; mem_req_ready = 1'b1;
    step();
    req_valid = 1'b0;
    vec++; if (mem_req_valid !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL sb_req got valid,done=%b%b exp 10", mem_req_valid, done); end
    vec++; if (mem_addr !== 32'h1000) begin errs++; $display("FAIL sb_addr got %h exp 00001000", mem_addr); end
    vec++; if (mem_we !== 4'b1000) begin errs++; $display("FAIL sb_we got %b exp 1000", mem_we); end
    vec++; if (mem_wdata !== 32'hA5A5A5A5) begin errs++; $display("FAIL sb_wdata got %h exp a5a5a5a5", mem_wdata); end
    step();
    vec++; if ({done, misalign} !== 2'b10) begin errs++; $display("FAIL sb_done got done,mis=%b exp 10", {done, misalign}); end
    step();
    vec++; if ({done, req_ready} !== 2'b01) begin errs++; $display("FAIL sb_idle got done,ready=%b exp 01", {done, req_ready}); end
  endtask

  task automatic test_load_half();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2002; req_ld_sel = LD_HALF; mem_req_ready = 1'b1;
    step();
    req_valid = 1'b0;
    vec++; if ({mem_req_valid, mem_we} !== 5'b10000 || mem_addr !== 32'h2000) begin errs++; $display("FAIL lh_req got valid,we=%b addr=%h exp 10000 00002000", {mem_req_valid, mem_we}, mem_addr); end
    step();
    for (int i = 0; i < 3; i++) begin
      vec++; if ({mem_req_valid, done} !== 2'b00) begin errs++; $display("FAIL lh_wait[%0d] got valid,done=%b exp 00", i, {mem_req_valid, done}); end
      if (i < 2) step();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h80011234;
    step();
    mem_rvalid = 1'b0;
    vec++; if ({done, misalign} !== 2'b10) begin errs++; $display("FAIL lh_done got done,mis=%b exp 10", {done, misalign}); end
    vec++; if (ld_data !== 32'h00008001) begin errs++; $display("FAIL lh_data got %h exp 00008001", ld_data); end
    vec++; if (ld_sel_out !== LD_HALF) begin errs++; $display("FAIL lh_sel got %b exp 001", ld_sel_out); end
    step();
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL lh_pulse got %b exp 0", done); end
  endtask

  task automatic test_misalign();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3001; req_ld_sel = LD_WORD;
    step();
    req_valid = 1'b0;
    vec++; if ({done, misalign, mem_req_valid} !== 3'b110) begin errs++; $display("FAIL mis_done got done,mis,valid=%b exp 110", {done, misalign, mem_req_valid}); end
    vec++; if (ld_data !== 32'h00008001) begin errs++; $display("FAIL mis_keep got %h exp 00008001", ld_data); end
    step();
    vec++; if ({done, misalign, mem_req_valid, req_ready} !== 4'b0001) begin errs++; $display("FAIL mis_after got %b exp 0001", {done, misalign, mem_req_valid, req_ready}); end
  endtask

  task automatic test_stall();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4002; req_wdata = 32'h0000BEEF; req_ld_sel = LD_HALF; mem_req_ready = 1'b0;
    step();
    req_addr = 32'h5000; req_wdata = 32'h12345678; req_ld_sel = LD_WORD;
    for (int i = 0; i < 5; i++) begin
      vec++; if ({req_ready, mem_req_valid, done} !== 3'b010) begin errs++; $display("FAIL st_busy[%0d] got ready,valid,done=%b exp 010", i, {req_ready, mem_req_valid, done}); end
      vec++; if (mem_addr !== 32'h4000 || mem_we !== 4'b1100 || mem_wdata !== 32'hBEEFBEEF) begin errs++; $display("FAIL st_hold[%0d] got %h %b %h exp 00004000 1100 beefbeef", i, mem_addr, mem_we, mem_wdata); end
      step();
    end
    req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    vec++; if ({done, misalign} !== 2'b10) begin errs++; $display("FAIL st_done got %b exp 10", {done, misalign}); end
    step();
    vec++; if ({mem_req_valid, done, req_ready} !== 3'b001) begin errs++; $display("FAIL st_no_reissue got %b exp 001", {mem_req_valid, done, req_ready}); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h6001; req_wdata = 32'h0000003C; req_ld_sel = LD_BYTE; mem_req_ready = 1'b1;
    step();
    vec++; if (mem_we !== 4'b0010 || mem_wdata !== 32'h3C3C3C3C) begin errs++; $display("FAIL bb_store got %b %h exp 0010 3c3c3c3c", mem_we, mem_wdata); end
    req_we = 1'b0; req_ld_sel = LD_BYTEU;
    step();
    vec++; if ({done, req_ready} !== 2'b10) begin errs++; $display("FAIL bb_done got done,ready=%b exp 10", {done, req_ready}); end
    step();
    vec++; if (req_ready !== 1'b1 || ld_data !== 32'h00008001) begin errs++; $display("FAIL bb_retain got ready=%b data=%h exp 1 00008001", req_ready, ld_data); end
    step();
    req_valid = 1'b0;
    vec++; if ({mem_req_valid, mem_we} !== 5'b10000) begin errs++; $display("FAIL bb_accept got %b exp 10000", {mem_req_valid, mem_we}); end
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    step();
    mem_rvalid = 1'b0;
    vec++; if (done !== 1'b1 || ld_data !== 32'h00112233 || ld_sel_out !== LD_BYTEU) begin errs++; $display("FAIL bb_load got done=%b data=%h sel=%b exp 1 00112233 100", done, ld_data, ld_sel_out); end
  endtask

  initial begin
    #1;
    test_reset();
    test_store_byte();
    test_load_half();
    test_misalign();
    test_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
